// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the data-memory arbiter: the FSM state encoding and
// the port index constants used by the arbiter and its round-robin pointer.
// No ports (package).
// -----------------------------------------------------------------------------
package arbitro_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    localparam logic PORTA_CPU   = 1'b0;
    localparam logic PORTA_CARGA = 1'b1;

endpackage

// File: rtl/ponteiro_rr.sv
// -----------------------------------------------------------------------------
// ponteiro_rr
// Round-robin pointer for the two-port data-memory arbiter. Holds the index of
// the last port served and picks the winner among the current requests.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_i        {m1_req, m0_req}
//   atualiza_i   strobe: store porta_i as the last port served
//   porta_i      index of the port just served
//   vencedor_o   winning port index (meaningful when valido_o is high)
//   valido_o     at least one request is pending
//   last_gnt_o   index of the last port served (1 out of reset)
// -----------------------------------------------------------------------------
module ponteiro_rr
    import arbitro_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       atualiza_i,
    input  logic       porta_i,
    output logic       vencedor_o,
    output logic       valido_o,
    output logic       last_gnt_o
);

    logic last_gnt_q;

    // Starting at PORTA_CARGA makes the CPU port win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= PORTA_CARGA;
        end else if (atualiza_i) begin
            last_gnt_q <= porta_i;
        end
    end

    always_comb begin
        valido_o = |req_i;
        case (req_i)
            2'b01:   vencedor_o = PORTA_CPU;
            2'b10:   vencedor_o = PORTA_CARGA;
            // On a tie the port that was not served last wins.
            2'b11:   vencedor_o = ~last_gnt_q;
            default: vencedor_o = PORTA_CPU;
        endcase
    end

    assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_dados
// Two-port arbiter in front of the single-port data memory. Port 0 is the CPU
// D_rd/D_wr path, port 1 the loader / I/O master. One transaction at a time:
// OCIOSO picks a winner and latches its command, ACESSO drives the memory for
// MEM_LAT cycles (reads) or one cycle (writes), CONCLUI pulses the winner's
// ack and always returns to OCIOSO, leaving one bubble between transactions.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   m0_req/wr/addr/wdata           port 0 command (hold stable until ack)
//   m0_ack, m0_rdata               port 0 completion pulse, registered read data
//   m1_*                           same for port 1
//   mem_addr/rd/wr/wdata           memory side, zero outside ACESSO
//   mem_rdata                      memory read data
//   busy                           FSM not idle
//   last_gnt                       index of the last port served
// -----------------------------------------------------------------------------
module arbitro_memoria_dados
    import arbitro_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              last_gnt
);

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    estado_t           estado_q, estado_d;
    logic [2:0]        cont_q, cont_d;
    logic              porta_q, porta_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              vencedor;
    logic              valido;
    logic              em_acesso;
    logic              em_conclui;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    ponteiro_rr u_ponteiro (
        .clk        (clk),
        .reset      (reset),
        .req_i      ({m1_req, m0_req}),
        .atualiza_i (em_conclui),
        .porta_i    (porta_q),
        .vencedor_o (vencedor),
        .valido_o   (valido),
        .last_gnt_o (last_gnt)
    );

    assign sel_wr    = (vencedor == PORTA_CARGA) ? m1_wr    : m0_wr;
    assign sel_addr  = (vencedor == PORTA_CARGA) ? m1_addr  : m0_addr;
    assign sel_wdata = (vencedor == PORTA_CARGA) ? m1_wdata : m0_wdata;

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        porta_d  = porta_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (estado_q)
            OCIOSO: begin
                if (valido) begin
                    porta_d  = vencedor;
                    wr_d     = sel_wr;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    cont_d   = sel_wr ? 3'd1 : LAT_C;
                    estado_d = ACESSO;
                end
            end
            ACESSO: begin
                cont_d = cont_q - 3'd1;
                // Last access cycle: memory data is valid now for a read.
                if (cont_q == 3'd1) begin
                    if (!wr_q) begin
                        if (porta_q == PORTA_CARGA) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                    estado_d = CONCLUI;
                end
            end
            CONCLUI: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cont_q   <= 3'd0;
            porta_q  <= PORTA_CPU;
            wr_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            porta_q  <= porta_d;
            wr_q     <= wr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Address/data latches are only observed through the ACESSO gating below,
    // so they need no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Memory side decoded from registered state only: no requester input can
    // reach the strobes combinationally, and reset clears them immediately.
    assign em_acesso  = (estado_q == ACESSO);
    assign em_conclui = (estado_q == CONCLUI);

    assign mem_addr  = em_acesso ? addr_q  : '0;
    assign mem_wdata = em_acesso ? wdata_q : '0;
    assign mem_rd    = em_acesso & ~wr_q;
    assign mem_wr    = em_acesso &  wr_q;

    assign m0_ack   = em_conclui & (porta_q == PORTA_CPU);
    assign m1_ack   = em_conclui & (porta_q == PORTA_CARGA);
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign busy     = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria_dados
// Directed bench for the data-memory arbiter (MEM_LAT = 3). Stimulus pushes the
// expected ack (port, cycle, both rdata registers) into a scoreboard queue; a
// monitor pops and compares on every ack. A behavioural 256x8 memory answers
// mem_rd combinationally; never-written locations read back as ~address.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria_dados;

    localparam int LAT = 3;
    localparam int P   = LAT + 2;   // read-to-read spacing when requests are held

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_wr, m1_req, m1_wr;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_rd, mem_wr;
    logic       busy, last_gnt;

    typedef struct {
        logic       porta;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t;

    bit [7:0] mem   [256];
    bit       wrote [256];

    arbitro_memoria_dados #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .last_gnt  (last_gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = wrote[mem_addr] ? mem[mem_addr] : ~mem_addr;

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr]   <= mem_wdata;
            wrote[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    task automatic push(input logic p, input logic [7:0] r0, input logic [7:0] r1, input int c);
        exp_t e;
        e.porta = p;
        e.rd0   = r0;
        e.rd1   = r1;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Returns at the negative edge inside cycle n.
    task automatic at_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // Waits until every expected ack has been seen, then steps 1 ns past a
    // rising edge so requests can be dropped before the next sampling edge.
    task automatic wait_drain(input string nome);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 60);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: %0d acks still pending after %0d cycles", nome, sb.size(), n);
            sb.delete();
        end
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_rd && mem_wr) begin
            n_chk++;
            n_fail++;
            $display("FAIL strobe_overlap: mem_rd and mem_wr both high at cycle %0d", cyc);
        end
        if (m0_ack || m1_ack) begin
            if (m0_ack && m1_ack) begin
                n_chk++;
                n_fail++;
                $display("FAIL dual_ack: both acks high at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: port %0d acked at cycle %0d, none expected", m1_ack, cyc);
            end else begin
                e = sb.pop_front();
                check("ack_port",   m1_ack,   e.porta);
                check("ack_cycle",  cyc,      e.cyc);
                check("ack_rdata0", m0_rdata, e.rd0);
                check("ack_rdata1", m1_rdata, e.rd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        m0_req   = 1'b0; m0_wr = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req   = 1'b0; m1_wr = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     busy, 1'b0);
        check("rst_last_gnt", last_gnt, 1'b1);
        check("rst_strobes",  {mem_rd, mem_wr, m0_ack, m1_ack}, 4'b0000);
        check("rst_mem_bus",  {mem_addr, mem_wdata}, 16'h0000);
        check("rst_rdata",    {m0_rdata, m1_rdata}, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Port 0 write 0x10 <- 0xA5
        m0_wr = 1'b1; m0_addr = 8'h10; m0_wdata = 8'hA5; m0_req = 1'b1;
        t = cyc + 1;
        push(1'b0, 8'h00, 8'h00, t + 1);
        at_cyc(t);
        check("wr_bus",  {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'h10, 8'hA5});
        check("wr_busy", busy, 1'b1);
        at_cyc(t + 1);
        check("wr_bubble_strobes", {mem_wr, mem_rd, mem_addr}, 10'h000);
        wait_drain("wr0");
        m0_req = 1'b0;
        check("wr_last_gnt", last_gnt, 1'b0);

        // Port 1 read 0x10, three-cycle latency
        m1_wr = 1'b0; m1_addr = 8'h10; m1_req = 1'b1;
        t = cyc + 1;
        push(1'b1, 8'h00, 8'hA5, t + LAT);
        for (int k = 0; k < LAT; k++) begin
            at_cyc(t + k);
            check("rd_strobe", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 8'h10});
        end
        at_cyc(t + LAT);
        check("rd_done_strobe", {mem_rd, mem_wr}, 2'b00);
        wait_drain("rd1");
        m1_req = 1'b0;

        // Both ports read continuously from reset: acks alternate 0,1,0,1
        reset = 1'b1;
        m0_wr = 1'b0; m0_addr = 8'h20; m0_req = 1'b1;
        m1_wr = 1'b0; m1_addr = 8'h30; m1_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        t = cyc + 1;
        push(1'b0, 8'hDF, 8'h00, t + LAT);
        push(1'b1, 8'hDF, 8'hCF, t + LAT + P);
        push(1'b0, 8'hDF, 8'hCF, t + LAT + 2 * P);
        push(1'b1, 8'hDF, 8'hCF, t + LAT + 3 * P);
        at_cyc(t + LAT);
        check("rr_last_gnt_before", last_gnt, 1'b1);
        at_cyc(t + LAT + 1);
        check("rr_last_gnt_0", last_gnt, 1'b0);
        at_cyc(t + LAT + P + 1);
        check("rr_last_gnt_1", last_gnt, 1'b1);
        wait_drain("rr");
        m0_req = 1'b0; m1_req = 1'b0;

        // Port 0 held high, port 1 write arrives mid-transaction
        m0_wr = 1'b0; m0_addr = 8'h10; m0_req = 1'b1;
        t = cyc + 1;
        push(1'b0, 8'hA5, 8'hCF, t + LAT);
        push(1'b1, 8'hA5, 8'hCF, t + LAT + 3);
        push(1'b0, 8'hA5, 8'hCF, t + 2 * LAT + 5);
        @(posedge clk);
        @(posedge clk); #1;
        m1_wr = 1'b1; m1_addr = 8'h40; m1_wdata = 8'h5A; m1_req = 1'b1;
        at_cyc(t + LAT + 2);
        check("mid_wr_bus", {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'h40, 8'h5A});
        @(posedge clk);
        @(posedge clk); #1;
        m1_req = 1'b0;
        wait_drain("mid");
        m0_req = 1'b0;

        // Reset during ACESSO of a write
        m0_wr = 1'b1; m0_addr = 8'h50; m0_wdata = 8'h77; m0_req = 1'b1;
        t = cyc + 1;
        at_cyc(t);
        check("abort_wr_active", mem_wr, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_strobes", {mem_wr, mem_rd, m0_ack, m1_ack}, 4'b0000);
        check("abort_busy",     busy, 1'b0);
        check("abort_last_gnt", last_gnt, 1'b1);
        m0_req = 1'b0;
        repeat (2) @(posedge clk);
        m0_wr = 1'b0; m0_addr = 8'h40; m0_req = 1'b1;
        m1_wr = 1'b0; m1_addr = 8'h10; m1_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        t = cyc + 1;
        push(1'b0, 8'h5A, 8'h00, t + LAT);
        push(1'b1, 8'h5A, 8'hA5, t + LAT + P);
        check("abort_no_mem_write", wrote[8'h50], 1'b0);
        wait_drain("post_abort");
        m0_req = 1'b0; m1_req = 1'b0;

        // Port 0 drops req one cycle after it is sampled
        m0_wr = 1'b0; m0_addr = 8'h20; m0_req = 1'b1;
        t = cyc + 1;
        push(1'b0, 8'hDF, 8'hA5, t + LAT);
        @(posedge clk); #1;
        m0_req = 1'b0;
        repeat (4 * P) @(posedge clk);
        @(negedge clk);
        check("drop_idle", busy, 1'b0);
        check("drop_pending", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
